// File: rtl/sub_serial_bla_if.sv
// Port bundle for the nibble-serial subtractor: request/operands in,
// status/result/flags out, plus FSM observation signals.
interface sub_serial_bla_if #(
    parameter int WIDTH = 32
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = $clog2(NIB);

    // Handshake: a request is taken on any rising edge where start = 1 and
    // busy = 0; start is ignored while busy = 1. done pulses for exactly one
    // cycle when d/bo/ovf/zero hold the completed result.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ovf;
    logic             zero;
    logic             dbg_exec;
    logic [KW-1:0]    dbg_k;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bo, ovf, zero, dbg_exec, dbg_k
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bo, ovf, zero, dbg_exec, dbg_k
    );
endinterface

// File: rtl/sub_serial_bla.sv
// Nibble-serial subtractor: D = A - B - BIN, one 4-bit look-ahead step per
// clock (A + ~B + ~borrow), with registered borrow/overflow/zero flags.
module sub_serial_bla #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    sub_serial_bla_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = $clog2(NIB);
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [KW-1:0]    k;
    logic             borrow;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] d_q;
    logic             bo_q;
    logic             ovf_q;
    logic             zero_q;
    logic             done_q;

    logic             accept;
    logic             step;
    logic             last;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       nib_res;
    logic [WIDTH-1:0] d_step;

    // 4-bit generate/propagate look-ahead; returns {carry_out, sum}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                step = 1'b1;
                if (k == K_LAST) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Nibble k of the latched operands, selected by the step counter.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIB; i++) begin
            if (k == KW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    // Subtraction as addition: invert the subtrahend, carry-in is NOT borrow.
    assign nib_res = cla4(a_nib, ~b_nib, ~borrow);

    always_comb begin
        d_step = d_q;
        for (int i = 0; i < NIB; i++) begin
            if (k == KW'(i)) begin
                d_step[4*i +: 4] = nib_res[3:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k      <= '0;
            borrow <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            bo_q   <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                a_q    <= bus.a;
                b_q    <= bus.b;
                borrow <= bus.bin;
                k      <= '0;
                d_q    <= '0;
            end
            if (step) begin
                d_q    <= d_step;
                borrow <= ~nib_res[4];
                k      <= last ? '0 : k + KW'(1);
            end
            // Flags are taken from the fully assembled difference.
            if (last) begin
                bo_q   <= ~nib_res[4];
                ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_step[WIDTH-1] != a_q[WIDTH-1]);
                zero_q <= (d_step == '0);
            end
        end
    end

    assign bus.busy     = (state == EXEC);
    assign bus.done     = done_q;
    assign bus.d        = d_q;
    assign bus.bo       = bo_q;
    assign bus.ovf      = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.dbg_exec = (state == EXEC);
    assign bus.dbg_k    = k;
endmodule

// File: tb/tb_sub_serial_bla.sv
// Directed bench for sub_serial_bla: arithmetic reference model checked every
// cycle, plus literal expectations for each directed vector.
module tb_sub_serial_bla;
  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;
  localparam int RW    = WIDTH + 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sub_serial_bla_if #(.WIDTH(WIDTH)) bus ();

  sub_serial_bla #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {ovf, zero, bo, d} from plain wide arithmetic.
  function automatic logic [RW-1:0] golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic bin);
    logic [WIDTH:0] diff;
    longint sa, sb, sd, smax, smin;
    logic ovf;
    diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    sa   = $signed(a);
    sb   = $signed(b);
    sd   = sa - sb - longint'(bin);
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -(longint'(1) <<< (WIDTH - 1));
    ovf  = (sd > smax) || (sd < smin);
    return {ovf, (diff[WIDTH-1:0] == '0), diff[WIDTH], diff[WIDTH-1:0]};
  endfunction

  // Cycle-level reference: nibble i of the result is visible after edge i+1.
  logic             started = 1'b0;
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  int               m_cnt = 0;
  logic [RW-1:0]    m_cur = '0;
  logic [WIDTH-1:0] m_d = '0;
  logic             m_bo = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_zero = 1'b0;

  always @(posedge clk) begin
    logic [WIDTH:0] one;
    logic [WIDTH:0] mask;
    one     = 1;
    started = 1'b1;
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_d = '0;
      m_bo = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
      exp_q.delete();
    end else if (!m_busy && bus.start) begin
      m_cur  = golden(bus.a, bus.b, bus.bin);
      exp_q.push_back(m_cur);
      m_busy = 1'b1; m_done = 1'b0; m_cnt = 0; m_d = '0;
    end else if (m_busy) begin
      m_cnt++;
      mask = (4 * m_cnt >= WIDTH) ? {(WIDTH+1){1'b1}} : (one << (4 * m_cnt)) - 1;
      m_d  = m_cur[WIDTH-1:0] & mask[WIDTH-1:0];
      m_done = 1'b0;
      if (m_cnt == NIB) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_ovf  = m_cur[WIDTH+2]; m_zero = m_cur[WIDTH+1]; m_bo = m_cur[WIDTH];
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [RW-1:0] r;
    if (started) begin
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("done", 64'(bus.done), 64'(m_done));
      check("d", 64'(bus.d), 64'(m_d));
      check("bo", 64'(bus.bo), 64'(m_bo));
      check("ovf", 64'(bus.ovf), 64'(m_ovf));
      check("zero", 64'(bus.zero), 64'(m_zero));
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("exp_q_has_entry", 64'(0), 64'(1));
        end else begin
          r = exp_q.pop_front();
          check("result", 64'({bus.ovf, bus.zero, bus.bo, bus.d}), 64'(r));
        end
      end
    end
  end

  // Issue one request, wait for done, check literal expectations.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input logic [WIDTH-1:0] exp_d, input logic exp_bo,
                        input logic exp_ovf, input logic exp_zero);
    int busy_cnt;
    logic got;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 3 * NIB && !got; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_done_seen"}, 64'(got), 64'(1));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(NIB));
    check({tag, "_d"}, 64'(bus.d), 64'(exp_d));
    check({tag, "_bo"}, 64'(bus.bo), 64'(exp_bo));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
    check({tag, "_zero"}, 64'(bus.zero), 64'(exp_zero));
  endtask

  // Model pins: a few hand-computed values the reference must reproduce.
  initial begin
    check("model_pin_wrap", 64'(golden(32'h0, 32'h1, 1'b0)), 64'({1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF}));
    check("model_pin_ovf", 64'(golden(32'h8000_0000, 32'h1, 1'b0)), 64'({1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF}));
    check("model_pin_bin", 64'(golden(32'h10, 32'hF, 1'b1)), 64'({1'b0, 1'b1, 1'b0, 32'h0}));
  end

  initial begin
    int gap;
    int done_seen;
    logic got;
    reset = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_d", 64'(bus.d), 64'(0));

    run_op("basic", 32'h5, 32'h3, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0);
    run_op("wrap", 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("sovf", 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op("equal", 32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    run_op("binzero", 32'h10, 32'hF, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    run_op("nibchain", 32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFE, 1'b0, 1'b0, 1'b0);

    // Second request held during busy: taken only in the done cycle.
    @(negedge clk);
    bus.a = 32'h100; bus.b = 32'h1; bus.bin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.a = 32'hFFFF_FFFF; bus.b = 32'h0;
    got = 1'b0;
    for (int i = 0; i < 3 * NIB && !got; i++) begin
      if (bus.done) got = 1'b1;
      else @(negedge clk);
    end
    check("b2b_first_done", 64'(got), 64'(1));
    check("b2b_first_d", 64'(bus.d), 64'(32'h0000_00FF));
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_second_accepted", 64'(bus.busy), 64'(1));
    check("b2b_done_dropped", 64'(bus.done), 64'(0));
    gap = 1;
    got = 1'b0;
    for (int i = 0; i < 3 * NIB && !got; i++) begin
      if (bus.done) got = 1'b1;
      else begin
        @(negedge clk);
        gap++;
      end
    end
    check("b2b_second_done", 64'(got), 64'(1));
    check("b2b_gap", 64'(gap), 64'(NIB + 1));
    check("b2b_second_d", 64'(bus.d), 64'(32'hFFFF_FFFF));
    check("b2b_second_bo", 64'(bus.bo), 64'(0));

    // Leave bo/ovf set so the reset below has something to clear.
    run_op("bothflags", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);

    @(negedge clk);
    bus.a = 32'h5555_AAAA; bus.b = 32'h1111_2222; bus.bin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_d", 64'(bus.d), 64'(0));
    check("rst_flags", 64'({bus.bo, bus.ovf, bus.zero}), 64'(0));
    done_seen = 0;
    for (int i = 0; i < 2 * NIB; i++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("rst_no_done", 64'(done_seen), 64'(0));

    run_op("after_rst", 32'h5555_AAAA, 32'h1111_2222, 1'b0, 32'h4444_8888, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
